instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Reader side of the 16-bit instruction memory. Generates word-aligned byte addresses (PC steps by 2) and issues requests with at most one outstanding. Buffers returned words with their PC in a small prefetch queue and presents them to decode through a valid/ready handshake. Handles branch redirects and stops fetching after the halt word 16'hEBCF.

Parameters:
RESET_PC, 16'h0000, byte address of the first fetch after reset.
DEPTH, 4, prefetch queue entries (power of 2, >= 2).
HALT_WORD, 16'hEBCF, instruction word that stops fetching.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
imem_req  out  1  request to memory; held high until imem_valid.
imem_addr  out  16  byte address of the request; bit 0 always 0.
imem_rdata  in  16  returned instruction word.
imem_valid  in  1  imem_rdata valid; completes the outstanding request.
instr_valid  out  1  queue head is valid.
instr_ready  in  1  decode accepts the head this cycle.
instr_out  out  16  head instruction word.
pc_out  out  16  byte address of the head instruction.
branch_taken  in  1  one-cycle redirect strobe.
branch_target  in  16  redirect byte address; bit 0 ignored.
halted  out  1  halt word fetched; no further requests.

Behaviour:
- Reset (async, any state): imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, pc_out=0, halted=0, queue empty, fetch_pc=RESET_PC, no outstanding request, drop flag clear.
- Issue: imem_req rises on the clock edge after a cycle with no outstanding request, halted=0, and (count + pending) < DEPTH. imem_addr=fetch_pc is held stable while imem_req=1.
- Completion: on a cycle with imem_req=1 and imem_valid=1, {imem_rdata, imem_addr} is pushed and fetch_pc += 2 (16-bit wrap: 16'hFFFE goes to 16'h0000). If space remains, imem_req stays high at the next address (back-to-back, one word per cycle at zero latency). imem_valid while imem_req=0 is ignored.
- Memory latency: any number of cycles >= 0 after imem_req rises (valid may arrive in the same cycle).
- Queue: FIFO of DEPTH entries. instr_valid=(count!=0). instr_out and pc_out come from the head. Pop when instr_valid & instr_ready. Push and pop in the same cycle leave count unchanged. The in-flight request is reserved against capacity, so no overflow is possible. When full, imem_req stays low until a pop.
- Halt: if a pushed word equals HALT_WORD, it is queued normally, halted=1 from the next cycle, and no further requests are issued. Queued entries still drain. Only rst or a redirect clears halted.
- Redirect (branch_taken=1):
  - Next cycle: queue empty, fetch_pc={branch_target[15:1],1'b0}, halted=0.
  - If a request is outstanding and not completed in the redirect cycle, its response is dropped when it arrives (drop flag). imem_req falls for that cycle, and the new fetch issues afterwards.
  - A response arriving in the redirect cycle itself is discarded.
  - A pop in the redirect cycle is still a completed transfer to decode.
- States:
  - IDLE: no request outstanding.
  - REQ: imem_req high.
  - DROP: awaiting a stale response, imem_req low.
  - HALT.
  - Transitions: IDLE->REQ on issue condition. REQ->REQ|IDLE|HALT on valid. REQ->DROP on redirect without valid. DROP->IDLE on valid. HALT->IDLE on redirect. Any state->reset on rst.
- All outputs are registered or driven from the queue head. There is no combinational path from instr_ready to imem_req.

Test Plan:
- Reset, memory with 1-cycle latency, instr_ready=1 -> imem_addr sequence 0x0000,0x0002,0x0004; first output instr_out=16'h012F, pc_out=0x0000; second 16'h012E, pc_out=0x0002.
- instr_ready=0 from reset -> queue fills with pc 0x0000..0x0006, instr_valid=1, imem_req=0 with imem_addr=0x0008; raise instr_ready -> one request issues after the first pop.
- 3-cycle latency; branch_taken with target 0x0021 while 0x000A is outstanding -> 0x000A data never appears on instr_out; next instr_valid shows pc_out=0x0020, instr_out=16'h212F.
- Word 16'hEBCF returned at 0x0032 -> presented with pc_out=0x0032, halted=1, imem_req stays 0 for 20 cycles; redirect to 0x0000 -> halted=0, fetch resumes at 0x0000.
- Assert rst mid-request with the queue holding 3 entries -> outputs immediately take their reset values, the queue is empty, and first fetch after release is RESET_PC.
- Simultaneous push and pop with the queue at DEPTH-1 and back-to-back zero latency -> count stable, no lost or duplicated PC across 16 words.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Reader side of the 16-bit instruction memory. Walks a byte-addressed PC in
// steps of 2, keeps at most one memory request in flight, parks returned words
// together with their PC in a small prefetch FIFO and hands them to decode over
// a valid/ready handshake. Branch redirects flush the FIFO and restart fetching
// at the target; fetching stops once the halt word has been fetched.
//
// Parameters:
//   RESET_PC   byte address of the first fetch after reset
//   DEPTH      prefetch queue entries (power of 2, >= 2)
//   HALT_WORD  instruction word that stops fetching
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   imem_req       out  memory request, held until imem_valid
//   imem_addr      out  byte address of the request (bit 0 always 0)
//   imem_rdata     in   returned instruction word
//   imem_valid     in   completes the outstanding request
//   instr_valid    out  queue head is valid
//   instr_ready    in   decode accepts the head this cycle
//   instr_out      out  head instruction word
//   pc_out         out  byte address of the head instruction
//   branch_taken   in   one-cycle redirect strobe
//   branch_target  in   redirect byte address (bit 0 ignored)
//   halted         out  halt word fetched, no further requests
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int          DEPTH     = 4,
   parameter logic [15:0] HALT_WORD = 16'hEBCF
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_valid,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [15:0] instr_out,
   output logic [15:0] pc_out,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   output logic        halted
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // IDLE: nothing in flight. REQ: request driven to memory.
   // DROP: waiting for the response of a request orphaned by a redirect.
   // HALT: halt word seen, fetching stopped until a redirect.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;
   localparam logic [1:0] ST_HALT = 2'd3;

   logic [1:0]    state;
   logic [1:0]    state_next;
   logic [15:0]   fetch_pc;
   logic [15:0]   instr_mem [DEPTH];
   logic [15:0]   pc_mem    [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_after;
   logic          push;
   logic          pop;

   // A response is only accepted for a live request; one arriving in the
   // redirect cycle belongs to the old instruction stream and is discarded.
   assign push = (state == ST_REQ) && imem_valid && !branch_taken;
   assign pop  = instr_valid && instr_ready;

   // Occupancy after this cycle's push, accounting for a simultaneous pop, so
   // a streaming queue at DEPTH-1 keeps the request line high.
   assign count_after = count + CW'(1) - CW'(pop);

   assign imem_req    = (state == ST_REQ);
   assign halted      = (state == ST_HALT);
   assign imem_addr   = fetch_pc;
   assign instr_valid = (count != '0);
   assign instr_out   = instr_valid ? instr_mem[rd_ptr] : 16'h0000;
   assign pc_out      = instr_valid ? pc_mem[rd_ptr]    : 16'h0000;

   // Fetch control. A redirect wins over everything else; if it catches a
   // request still in flight, the stale response must be swallowed (DROP)
   // before a new request can go out. Issue from IDLE looks only at the
   // registered count, keeping instr_ready out of the request decision path.
   always_comb begin
      state_next = state;
      if (branch_taken) begin
         if ((state == ST_REQ || state == ST_DROP) && !imem_valid) begin
            state_next = ST_DROP;
         end else begin
            state_next = ST_IDLE;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (count < CW'(DEPTH)) begin
                  state_next = ST_REQ;
               end
            end
            ST_REQ: begin
               if (imem_valid) begin
                  if (imem_rdata == HALT_WORD) begin
                     state_next = ST_HALT;
                  end else if (count_after < CW'(DEPTH)) begin
                     state_next = ST_REQ;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end
            end
            ST_DROP: begin
               if (imem_valid) begin
                  state_next = ST_IDLE;
               end
            end
            ST_HALT: begin
               state_next = ST_HALT;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // State and fetch PC. The PC only advances on an accepted word, so it
   // stays stable for the whole life of a request; 16-bit wrap is natural.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         fetch_pc <= RESET_PC;
      end else begin
         state <= state_next;
         if (branch_taken) begin
            fetch_pc <= branch_target & 16'hFFFE;
         end else if (push) begin
            fetch_pc <= fetch_pc + 16'd2;
         end
      end
   end

   // Queue bookkeeping. A redirect empties the queue; a pop in that same
   // cycle has already been seen by decode and needs no further handling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (branch_taken) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (!push && pop) begin
            count <= count - CW'(1);
         end
      end
   end

   // Queue storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= imem_rdata;
         pc_mem[wr_ptr]    <= fetch_pc;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Testbench for instr_fetch_unit. A behavioural model (queue of {word, pc},
// fetch pointer, request/drop/halt flags) is stepped once per cycle from the
// same inputs as the DUT, and every cycle the DUT outputs are compared
// against it. A memory responder with configurable latency serves requests
// from a word array. Directed scenarios pin specific expectations, then a
// randomized phase mixes latency, back-pressure and redirects.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

   localparam logic [15:0] HALT = 16'hEBCF;
   localparam int          QDEPTH = 4;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_valid;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr_out;
   logic [15:0] pc_out;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic        halted;

   int vectors     = 0;
   int miscompares = 0;

   // stimulus knobs
   int          lat_min;
   int          lat_max;
   int          ready_mode;
   int          br_rate;
   bit          br_now;
   logic [15:0] br_tgt;

   // memory responder
   logic [15:0] mem [32768];
   bit          resp_active;
   int          resp_wait;
   logic [15:0] resp_addr;

   // behavioural model
   entry_t      mq[$];
   logic [15:0] m_pc;
   bit          m_req;
   bit          m_drop;
   bit          m_halt;
   logic [15:0] popped_pc[$];
   logic [15:0] popped_instr[$];
   logic [15:0] accepted[$];

   instr_fetch_unit #(
      .RESET_PC (16'h0000),
      .DEPTH    (QDEPTH),
      .HALT_WORD(HALT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .imem_valid   (imem_valid),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr_out    (instr_out),
      .pc_out       (pc_out),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   task automatic checkWord(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mq.delete();
      popped_pc.delete();
      popped_instr.delete();
      accepted.delete();
      m_pc   = 16'h0000;
      m_req  = 1'b0;
      m_drop = 1'b0;
      m_halt = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic modelStep();
      int cnt_start;
      cnt_start = mq.size();
      if (cnt_start != 0 && instr_ready) begin
         popped_pc.push_back(mq[0].pc);
         popped_instr.push_back(mq[0].instr);
         void'(mq.pop_front());
      end
      if (branch_taken) begin
         mq.delete();
         if (m_req && !imem_valid) begin
            m_drop = 1'b1;
         end else if (m_drop && imem_valid) begin
            m_drop = 1'b0;
         end
         m_req  = 1'b0;
         m_halt = 1'b0;
         m_pc   = {branch_target[15:1], 1'b0};
      end else if (m_drop) begin
         if (imem_valid) m_drop = 1'b0;
      end else if (m_req) begin
         if (imem_valid) begin
            mq.push_back(entry_t'{imem_rdata, m_pc});
            accepted.push_back(m_pc);
            m_pc = m_pc + 16'd2;
            if (imem_rdata == HALT) m_halt = 1'b1;
            m_req = !m_halt && (mq.size() < QDEPTH);
         end
      end else begin
         m_req = !m_halt && (cnt_start < QDEPTH);
      end
   endtask

   task automatic checkOutput();
      checkBit ("imem_req",    imem_req,    m_req);
      checkWord("imem_addr",   imem_addr,   m_pc);
      checkBit ("instr_valid", instr_valid, mq.size() != 0);
      checkBit ("halted",      halted,      m_halt);
      if (mq.size() != 0) begin
         checkWord("instr_out", instr_out, mq[0].instr);
         checkWord("pc_out",    pc_out,    mq[0].pc);
      end
   endtask

   task automatic applyStimulus();
      imem_valid = 1'b0;
      imem_rdata = 16'($urandom);
      if (!resp_active && imem_req) begin
         resp_active = 1'b1;
         resp_wait   = $urandom_range(lat_max, lat_min);
         resp_addr   = imem_addr;
      end
      if (resp_active) begin
         if (resp_wait == 0) begin
            imem_valid  = 1'b1;
            imem_rdata  = mem[resp_addr[15:1]];
            resp_active = 1'b0;
         end else begin
            resp_wait--;
         end
      end else if (!imem_req && $urandom_range(7, 0) == 0) begin
         imem_valid = 1'b1;
      end
      case (ready_mode)
         0:       instr_ready = 1'b0;
         1:       instr_ready = 1'b1;
         default: instr_ready = ($urandom_range(3, 0) != 0);
      endcase
      branch_taken  = 1'b0;
      branch_target = 16'($urandom);
      if (br_now) begin
         branch_taken  = 1'b1;
         branch_target = br_tgt;
         br_now        = 1'b0;
      end else if (br_rate != 0 && $urandom_range(br_rate - 1, 0) == 0) begin
         branch_taken  = 1'b1;
         branch_target = ($urandom_range(7, 0) == 0) ? 16'hFFF9 : 16'($urandom_range(127, 0));
      end
   endtask

   task automatic step();
      checkOutput();
      applyStimulus();
      modelStep();
      @(negedge clk);
   endtask

   task automatic doReset();
      rst           = 1'b1;
      resp_active   = 1'b0;
      imem_valid    = 1'b0;
      imem_rdata    = 16'h0000;
      instr_ready   = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 16'h0000;
      br_now        = 1'b0;
      br_rate       = 0;
      modelReset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit          found;
      int          mark;
      int          bad;
      int          req_hi;
      logic [15:0] w;

      for (int i = 0; i < 32768; i++) begin
         w = 16'($urandom);
         if (w == HALT) w = 16'h0000;
         mem[i] = w;
      end
      mem[16'h0000] = 16'h012F;
      mem[16'h0001] = 16'h012E;
      mem[16'h0010] = 16'h212F;
      mem[16'h0019] = HALT;

      // Reset values, then 1-cycle latency with decode always ready.
      $display("[TB] scenario: reset and sequential fetch");
      lat_min = 1; lat_max = 1; ready_mode = 1;
      doReset();
      checkBit ("rst_imem_req",    imem_req,    1'b0);
      checkWord("rst_imem_addr",   imem_addr,   16'h0000);
      checkBit ("rst_instr_valid", instr_valid, 1'b0);
      checkWord("rst_instr_out",   instr_out,   16'h0000);
      checkWord("rst_pc_out",      pc_out,      16'h0000);
      checkBit ("rst_halted",      halted,      1'b0);
      for (int i = 0; i < 12; i++) step();
      checkBit("s1_enough_words", accepted.size() >= 3 && popped_pc.size() >= 2, 1'b1);
      if (accepted.size() >= 3 && popped_pc.size() >= 2) begin
         checkWord("s1_addr0",  accepted[0],     16'h0000);
         checkWord("s1_addr1",  accepted[1],     16'h0002);
         checkWord("s1_addr2",  accepted[2],     16'h0004);
         checkWord("s1_instr0", popped_instr[0], 16'h012F);
         checkWord("s1_pc0",    popped_pc[0],    16'h0000);
         checkWord("s1_instr1", popped_instr[1], 16'h012E);
         checkWord("s1_pc1",    popped_pc[1],    16'h0002);
      end

      // Decode stalled: queue fills, request line parks at the next address.
      $display("[TB] scenario: queue full");
      lat_min = 0; lat_max = 2; ready_mode = 0;
      doReset();
      for (int i = 0; i < 20; i++) step();
      checkBit ("s2_req_low",    imem_req,    1'b0);
      checkWord("s2_addr",       imem_addr,   16'h0008);
      checkBit ("s2_valid",      instr_valid, 1'b1);
      checkWord("s2_head_pc",    pc_out,      16'h0000);
      checkWord("s2_head_instr", instr_out,   16'h012F);
      ready_mode = 1;
      step();
      ready_mode = 0;
      found = 1'b0;
      for (int i = 0; i < 5 && !found; i++) begin
         if (imem_req) found = 1'b1;
         else step();
      end
      checkBit ("s2_req_after_pop",  found,     1'b1);
      checkWord("s2_addr_after_pop", imem_addr, 16'h0008);
      for (int i = 0; i < 6; i++) step();

      // Redirect while the fetch of 0x000A is still in flight.
      $display("[TB] scenario: redirect with outstanding request");
      lat_min = 3; lat_max = 3; ready_mode = 1;
      doReset();
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (imem_req && imem_addr == 16'h000A) found = 1'b1;
         else step();
      end
      checkBit("s3_reached_000a", found, 1'b1);
      br_now = 1'b1;
      br_tgt = 16'h0021;
      step();
      mark = popped_pc.size();
      for (int i = 0; i < 30; i++) step();
      bad = 0;
      foreach (popped_pc[i]) if (popped_pc[i] == 16'h000A) bad++;
      checkWord("s3_stale_seen", 16'(bad), 16'd0);
      checkBit("s3_post_branch_pop", popped_pc.size() > mark, 1'b1);
      if (popped_pc.size() > mark) begin
         checkWord("s3_first_pc",    popped_pc[mark],    16'h0020);
         checkWord("s3_first_instr", popped_instr[mark], 16'h212F);
      end

      // Halt word at 0x0032, then resume through a redirect to 0x0000.
      $display("[TB] scenario: halt and resume");
      lat_min = 0; lat_max = 1; ready_mode = 1;
      doReset();
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (instr_valid && pc_out == 16'h0032) found = 1'b1;
         else step();
      end
      checkBit ("s4_halt_presented", found,     1'b1);
      checkWord("s4_halt_instr",     instr_out, HALT);
      checkBit ("s4_halted",         halted,    1'b1);
      req_hi = 0;
      for (int i = 0; i < 20; i++) begin
         if (imem_req) req_hi++;
         step();
      end
      checkWord("s4_req_while_halted", 16'(req_hi), 16'd0);
      checkBit ("s4_still_halted",     halted,      1'b1);
      br_now = 1'b1;
      br_tgt = 16'h0000;
      step();
      checkBit("s4_unhalted", halted, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (imem_req) found = 1'b1;
         else step();
      end
      checkBit ("s4_resumed",     found,     1'b1);
      checkWord("s4_resume_addr", imem_addr, 16'h0000);
      for (int i = 0; i < 6; i++) step();

      // Asynchronous reset mid-request with three entries queued.
      $display("[TB] scenario: async reset mid-request");
      lat_min = 2; lat_max = 2; ready_mode = 0;
      doReset();
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (mq.size() == 3 && imem_req) found = 1'b1;
         else step();
      end
      checkBit("s5_three_queued", found, 1'b1);
      #2 rst = 1'b1;
      #1;
      checkBit ("s5_req",    imem_req,    1'b0);
      checkWord("s5_addr",   imem_addr,   16'h0000);
      checkBit ("s5_valid",  instr_valid, 1'b0);
      checkWord("s5_instr",  instr_out,   16'h0000);
      checkWord("s5_pc",     pc_out,      16'h0000);
      checkBit ("s5_halted", halted,      1'b0);
      lat_min = 1; lat_max = 1; ready_mode = 1;
      doReset();
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (imem_req) found = 1'b1;
         else step();
      end
      checkBit ("s5_refetch",      found,     1'b1);
      checkWord("s5_refetch_addr", imem_addr, 16'h0000);

      // Zero-latency streaming with the queue held at DEPTH-1.
      $display("[TB] scenario: streaming at DEPTH-1");
      lat_min = 0; lat_max = 0; ready_mode = 0;
      doReset();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (mq.size() == QDEPTH - 1) found = 1'b1;
         else step();
      end
      checkBit("s6_reached_depth_m1", found, 1'b1);
      ready_mode = 1;
      mark   = popped_pc.size();
      req_hi = 0;
      bad    = 0;
      for (int i = 0; i < 16; i++) begin
         if (imem_req) req_hi++;
         step();
         if (mq.size() != QDEPTH - 1) bad++;
      end
      checkWord("s6_req_cycles",  16'(req_hi), 16'd16);
      checkWord("s6_count_moves", 16'(bad),    16'd0);
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (mark + i >= popped_pc.size() || popped_pc[mark + i] != 16'(2 * i)) bad++;
      end
      checkWord("s6_pc_sequence", 16'(bad), 16'd0);

      // Randomized traffic with redirects.
      $display("[TB] scenario: random");
      lat_min = 0; lat_max = 3; ready_mode = 2;
      doReset();
      br_rate = 25;
      for (int i = 0; i < 3000; i++) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
